baud_tick_ctrl: RTL

- Controls the UART baud-rate tick counter: owns the mod-M divisor, sequences start/stop, and realigns phase.
- Outputs the oversample tick (s_tick) for the rx/tx FSMs and a derived bit tick (b_tick).
- Accepts runtime divisor changes over a valid/ready handshake and applies them only at a tick boundary, so no truncated or overlong period is ever produced.
- The rx path uses sync_req to realign the counter phase on start-bit detection.

---
 rtl/baud_tick_ctrl_if.sv | 30 +++
 rtl/baud_tick_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/baud_tick_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | baud_tick_ctrl_if : run/config/sync controls and tick/status bus    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface baud_tick_ctrl_if #(
  parameter int N = 11
);
  logic         en;
  logic         cfg_valid;
  logic [N-1:0] cfg_dvsr;
  logic         cfg_ready;
  logic         sync_req;
  logic         s_tick;
  logic         b_tick;
  logic [N-1:0] dvsr;
  logic [N-1:0] q;
  logic         pending;

  modport master (
    output en, cfg_valid, cfg_dvsr, sync_req,
    input  cfg_ready, s_tick, b_tick, dvsr, q, pending
  );

  modport slave (
    input  en, cfg_valid, cfg_dvsr, sync_req,
    output cfg_ready, s_tick, b_tick, dvsr, q, pending
  );
endinterface
`default_nettype wire

// File: rtl/baud_tick_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | baud_tick_ctrl : mod-M oversample/bit tick generator with          |
// | tick-aligned divisor updates and phase realignment. Rev 1.0         |
// +--------------------------------------------------------------------+
module baud_tick_ctrl #(
  parameter int N        = 11,
  parameter int DVSR_RST = 326,
  parameter int OS       = 16
) (
  input  wire logic        clk,
  input  wire logic        reset,
  baud_tick_ctrl_if.slave  bus
);

  localparam int             OSW     = (OS > 1) ? $clog2(OS) : 1;
  localparam logic [OSW-1:0] OS_LAST = OSW'(OS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [OSW-1:0] os_q, os_d;
  logic [N-1:0]   dvsr_q, dvsr_d;
  logic [N-1:0]   pend_q, pend_d;

  logic [N-1:0]   dvsr_eff;
  logic           s_tick;
  logic           b_tick;
  logic           cfg_ready;
  logic           xfer;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      os_q    <= '0;
      dvsr_q  <= N'(DVSR_RST);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      os_q    <= os_d;
      dvsr_q  <= dvsr_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    os_d    = os_q;
    dvsr_d  = dvsr_q;
    pend_d  = pend_q;
    xfer    = bus.cfg_valid && cfg_ready;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        os_d  = '0;
        if (xfer)   dvsr_d  = bus.cfg_dvsr;
        if (bus.en) state_d = S_RUN;
      end
      S_RUN, S_PEND: begin
        if (!bus.en) begin
          // A pending divisor is never lost on stop; a same-cycle offer goes straight in.
          state_d = S_IDLE;
          cnt_d   = '0;
          os_d    = '0;
          if (state_q == S_PEND) dvsr_d = pend_q;
          else if (xfer)         dvsr_d = bus.cfg_dvsr;
        end else begin
          if (bus.sync_req) begin
            cnt_d = '0;
            os_d  = '0;
          end else if (s_tick) begin
            cnt_d = '0;
            os_d  = (os_q == OS_LAST) ? '0 : os_q + OSW'(1);
          end else begin
            cnt_d = cnt_q + N'(1);
          end
          if (state_q == S_PEND) begin
            if (bus.sync_req || s_tick) begin
              dvsr_d  = pend_q;
              state_d = S_RUN;
            end
          end else if (xfer) begin
            pend_d  = bus.cfg_dvsr;
            state_d = S_PEND;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        os_d    = '0;
      end
    endcase
  end

  // Ticks decode from registers only, so no input reaches an output combinationally.
  always_comb begin
    dvsr_eff  = (dvsr_q < N'(2)) ? N'(1) : dvsr_q;
    s_tick    = (state_q != S_IDLE) && (cnt_q == dvsr_eff - N'(1));
    b_tick    = s_tick && (os_q == OS_LAST);
    cfg_ready = (state_q != S_PEND);
  end

  assign bus.s_tick    = s_tick;
  assign bus.b_tick    = b_tick;
  assign bus.cfg_ready = cfg_ready;
  assign bus.dvsr      = dvsr_q;
  assign bus.q         = cnt_q;
  assign bus.pending   = (state_q == S_PEND);

endmodule
`default_nettype wire
